// File: rtl/thread_cmd_arbiter_if.sv
// Command/response bundle between the per-CPU command buses, the arbiter and the threads manager.
// master: the arbiter's view; slave: the environment (CPUs + manager) view.
interface thread_cmd_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32
);
  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req_vld;
  logic [4*N_REQ-1:0]  req_cmd;
  logic [AW*N_REQ-1:0] req_addr;
  logic [DW*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_done;
  logic [1:0]          req_rslt;
  logic [DW-1:0]       req_rdata;

  logic                tm_req;
  logic [3:0]          tm_cmd;
  logic [AW-1:0]       tm_addr;
  logic [DW-1:0]       tm_data;
  logic                tm_ack;
  logic [1:0]          tm_rslt;
  logic [DW-1:0]       tm_rdata;

  logic                busy;
  logic [GW-1:0]       gnt_id;

  modport master (
    input  req_vld, req_cmd, req_addr, req_data, tm_ack, tm_rslt, tm_rdata,
    output req_done, req_rslt, req_rdata, tm_req, tm_cmd, tm_addr, tm_data, busy, gnt_id
  );

  modport slave (
    output req_vld, req_cmd, req_addr, req_data, tm_ack, tm_rslt, tm_rdata,
    input  req_done, req_rslt, req_rdata, tm_req, tm_cmd, tm_addr, tm_data, busy, gnt_id
  );
endinterface

// File: rtl/thread_cmd_arbiter.sv
// Round-robin arbiter sharing the threads-manager command port among N_REQ CPUs.
// Optional WAIT-state abort after TIMEOUT cycles without tm_ack: define THRD_ARB_TIMEOUT_EN.
module thread_cmd_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 32,
`ifdef THRD_ARB_TIMEOUT_EN
  parameter int unsigned TIMEOUT  = 16,
`endif
  parameter logic [3:0]  CMD_RUN  = 4'h1,
  parameter logic [3:0]  CMD_STOP = 4'h2
) (
  input  logic                  clk,
  input  logic                  rst,
  thread_cmd_arbiter_if.master  bus
);
  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = GW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [GW-1:0]   last_gnt;
  logic [CW-1:0]   cand;
  logic [GW-1:0]   pick_idx;
  logic            pick_vld;
  logic [3:0]      pick_cmd;
  logic            pick_tm;

`ifdef THRD_ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0]   wait_cnt;
`endif

  // Round-robin pick: scan from the farthest offset down so the nearest set bit after last_gnt wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = CW'(last_gnt) + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (bus.req_vld[GW'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = GW'(cand);
      end
    end
  end

  assign pick_cmd = bus.req_cmd[4*int'(pick_idx) +: 4];
  assign pick_tm  = (pick_cmd == CMD_RUN) || (pick_cmd == CMD_STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_gnt      <= GW'(N_REQ - 1);
      bus.tm_req    <= 1'b0;
      bus.tm_cmd    <= '0;
      bus.tm_addr   <= '0;
      bus.tm_data   <= '0;
      bus.req_done  <= '0;
      bus.req_rslt  <= '0;
      bus.req_rdata <= '0;
      bus.busy      <= 1'b0;
      bus.gnt_id    <= '0;
`ifdef THRD_ARB_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            bus.gnt_id <= pick_idx;
            bus.busy   <= 1'b1;
            if (pick_tm) begin
              bus.tm_req  <= 1'b1;
              bus.tm_cmd  <= pick_cmd;
              bus.tm_addr <= bus.req_addr[AW*int'(pick_idx) +: AW];
              bus.tm_data <= bus.req_data[DW*int'(pick_idx) +: DW];
              state       <= WAIT;
`ifdef THRD_ARB_TIMEOUT_EN
              wait_cnt    <= '0;
`endif
            end else begin
              // Non-manager commands complete locally with a zero result.
              bus.req_done  <= N_REQ'(1) << pick_idx;
              bus.req_rslt  <= '0;
              bus.req_rdata <= '0;
              state         <= RESP;
            end
          end
        end
        WAIT: begin
          if (bus.tm_ack) begin
            bus.tm_req    <= 1'b0;
            bus.tm_cmd    <= '0;
            bus.tm_addr   <= '0;
            bus.tm_data   <= '0;
            bus.req_done  <= N_REQ'(1) << bus.gnt_id;
            bus.req_rslt  <= bus.tm_rslt;
            bus.req_rdata <= bus.tm_rdata;
            state         <= RESP;
          end
`ifdef THRD_ARB_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            bus.tm_req    <= 1'b0;
            bus.tm_cmd    <= '0;
            bus.tm_addr   <= '0;
            bus.tm_data   <= '0;
            bus.req_done  <= N_REQ'(1) << bus.gnt_id;
            bus.req_rslt  <= 2'b10;
            bus.req_rdata <= '0;
            state         <= RESP;
          end else begin
            wait_cnt      <= wait_cnt + TW'(1);
          end
`endif
        end
        RESP: begin
          bus.req_done  <= '0;
          bus.req_rslt  <= '0;
          bus.req_rdata <= '0;
          bus.busy      <= 1'b0;
          last_gnt      <= bus.gnt_id;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_thread_cmd_arbiter.sv
// Bench for thread_cmd_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Honours THRD_ARB_TIMEOUT_EN when the design is built with it.
module tb_thread_cmd_arbiter;
  localparam int N   = 4;
  localparam int TO  = 16;
  localparam logic [3:0] RUN  = 4'h1;
  localparam logic [3:0] STOP = 4'h2;

  logic clk, rst;
  int   n_cmp, n_err;
  bit   chk_on;

  thread_cmd_arbiter_if #(.N_REQ(N), .DW(32), .AW(32)) bus ();

  thread_cmd_arbiter #(.N_REQ(N), .DW(32), .AW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_op, m_res;
  int          m_own, m_last, m_gid, m_wait;
  logic [3:0]  m_cmd;
  logic [31:0] m_addr, m_data, m_rdata;
  logic [1:0]  m_rslt;
  int          starve [N];

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int off = 1; off <= N; off++)
      if (v[(last + off) % N]) return (last + off) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_op = 0; m_res = 0; m_last = N - 1; m_gid = 0;
      foreach (starve[i]) starve[i] = 0;
    end else if (m_op && m_res) begin
      m_op = 0; m_res = 0; m_last = m_own;
    end else if (m_op) begin
      if (bus.tm_ack) begin
        m_res = 1; m_rslt = bus.tm_rslt; m_rdata = bus.tm_rdata;
      end else begin
        m_wait++;
`ifdef THRD_ARB_TIMEOUT_EN
        if (m_wait == TO) begin m_res = 1; m_rslt = 2'b10; m_rdata = '0; end
`endif
      end
    end else if (bus.req_vld != '0) begin
      m_own  = rr_pick(bus.req_vld, m_last);
      m_gid  = m_own;
      m_cmd  = bus.req_cmd[4*m_own +: 4];
      m_addr = bus.req_addr[32*m_own +: 32];
      m_data = bus.req_data[32*m_own +: 32];
      m_op   = 1; m_wait = 0;
      if (m_cmd != RUN && m_cmd != STOP) begin m_res = 1; m_rslt = '0; m_rdata = '0; end
      for (int i = 0; i < N; i++) begin
        if (i == m_own || !bus.req_vld[i]) starve[i] = 0;
        else begin
          starve[i]++;
          chk($sformatf("fairness_cpu%0d", i), 64'(starve[i] <= N - 1), 64'd1);
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      logic            e_tm;
      logic [N-1:0]    e_done;
      e_tm   = m_op && !m_res;
      e_done = (m_op && m_res) ? N'(1) << m_own : '0;
      chk("tm_req",    64'(bus.tm_req),    64'(e_tm));
      chk("tm_cmd",    64'(bus.tm_cmd),    e_tm ? 64'(m_cmd)  : 64'd0);
      chk("tm_addr",   64'(bus.tm_addr),   e_tm ? 64'(m_addr) : 64'd0);
      chk("tm_data",   64'(bus.tm_data),   e_tm ? 64'(m_data) : 64'd0);
      chk("req_done",  64'(bus.req_done),  64'(e_done));
      chk("req_rslt",  64'(bus.req_rslt),  e_done != '0 ? 64'(m_rslt)  : 64'd0);
      chk("req_rdata", 64'(bus.req_rdata), e_done != '0 ? 64'(m_rdata) : 64'd0);
      chk("busy",      64'(bus.busy),      64'(m_op));
      chk("gnt_id",    64'(bus.gnt_id),    64'(m_gid));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    bus.req_vld[i]          = 1'b1;
    bus.req_cmd[4*i +: 4]   = c;
    bus.req_addr[32*i +: 32] = a;
    bus.req_data[32*i +: 32] = d;
  endtask

  task automatic wait_done(output int idx);
    idx = -1;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (bus.req_done != '0) begin
        for (int i = 0; i < N; i++) if (bus.req_done[i]) idx = i;
        return;
      end
    end
    n_cmp++; n_err++;
    $display("FAIL done_timeout: got no req_done, expected one within 60 cycles");
  endtask

  initial begin
    int idx, cnt;
    int order [8];
    n_cmp = 0; n_err = 0; chk_on = 0;
    rst = 1'b1;
    bus.req_vld = '0; bus.req_cmd = '0; bus.req_addr = '0; bus.req_data = '0;
    bus.tm_ack = 1'b0; bus.tm_rslt = '0; bus.tm_rdata = '0;
    tick(); tick();
    chk("rst_tm_req", 64'(bus.tm_req), 64'd0);
    chk("rst_done",   64'(bus.req_done), 64'd0);
    chk("rst_busy",   64'(bus.busy), 64'd0);
    chk("rst_gnt",    64'(bus.gnt_id), 64'd0);
    rst = 1'b0; chk_on = 1;
    tick();

    // Single RUN on CPU0, ack one cycle after tm_req rises.
    set_req(0, RUN, 32'h100, 32'h5);
    tick();
    chk("t1_tm_req",  64'(bus.tm_req), 64'd1);
    chk("t1_tm_cmd",  64'(bus.tm_cmd), 64'(RUN));
    chk("t1_tm_addr", 64'(bus.tm_addr), 64'h100);
    chk("t1_tm_data", 64'(bus.tm_data), 64'h5);
    tick();
    chk("t1_tm_hold", 64'(bus.tm_req), 64'd1);
    bus.tm_ack = 1'b1; bus.tm_rslt = 2'd1; bus.tm_rdata = 32'hFFFF_FFFF;
    tick();
    chk("t1_done",  64'(bus.req_done), 64'h1);
    chk("t1_rslt",  64'(bus.req_rslt), 64'd1);
    chk("t1_rdata", 64'(bus.req_rdata), 64'hFFFF_FFFF);
    bus.req_vld = '0; bus.tm_ack = 1'b0;
    tick();
    chk("t1_idle", 64'(bus.busy), 64'd0);

    // Fairness: all four held, then only 0 and 2.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, (i % 2) ? STOP : RUN, 32'(i), 32'(i * 3));
    bus.tm_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin wait_done(idx); order[k] = idx; end
    bus.req_vld = 4'b0101;
    for (int k = 4; k < 8; k++) begin wait_done(idx); order[k] = idx; end
    for (int k = 0; k < 4; k++) chk($sformatf("rr_all_%0d", k), 64'(order[k]), 64'(k));
    for (int k = 4; k < 8; k++) chk($sformatf("rr_02_%0d", k), 64'(order[k]), (k % 2) ? 64'd2 : 64'd0);
    bus.req_vld = '0; bus.tm_ack = 1'b0;
    tick(); tick();

    // Unknown command: completes locally with zero result.
    set_req(1, 4'hF, 32'h200, 32'h9);
    wait_done(idx);
    chk("t3_idx",   64'(idx), 64'd1);
    chk("t3_rslt",  64'(bus.req_rslt), 64'd0);
    chk("t3_tmreq", 64'(bus.tm_req), 64'd0);
    bus.req_vld = '0;
    tick();

    // Silent manager.
    set_req(2, RUN, 32'h300, 32'h7);
    tick();
    cnt = 0;
    while (bus.tm_req && cnt < 40) begin cnt++; tick(); end
`ifdef THRD_ARB_TIMEOUT_EN
    chk("t4_to_len",  64'(cnt), 64'(TO));
    chk("t4_to_done", 64'(bus.req_done), 64'h4);
    chk("t4_to_rslt", 64'(bus.req_rslt), 64'h2);
`else
    chk("t4_hold_len", 64'(cnt), 64'd40);
    bus.tm_ack = 1'b1; bus.tm_rslt = 2'd3; bus.tm_rdata = 32'hABCD;
    tick();
    chk("t4_late_done", 64'(bus.req_done), 64'h4);
`endif
    bus.req_vld = '0; bus.tm_ack = 1'b0;
    tick();

    // Reset during WAIT aborts; CPU0 wins afterwards.
    set_req(1, RUN, 32'h400, 32'h1);
    tick();
    chk("t5_wait", 64'(bus.tm_req), 64'd1);
    rst = 1'b1;
    tick();
    chk("t5_abort_tm",   64'(bus.tm_req), 64'd0);
    chk("t5_abort_done", 64'(bus.req_done), 64'd0);
    rst = 1'b0;
    set_req(0, STOP, 32'h500, 32'h2);
    bus.tm_ack = 1'b1; bus.tm_rslt = 2'd2; bus.tm_rdata = 32'h55;
    wait_done(idx);
    chk("t5_first", 64'(idx), 64'd0);
    bus.req_vld = '0; bus.tm_ack = 1'b0;
    tick(); tick();

    // Ack coinciding with a new request from CPU3.
    set_req(1, RUN, 32'h600, 32'h3);
    tick(); tick();
    bus.tm_ack = 1'b1; bus.tm_rslt = 2'd1; bus.tm_rdata = 32'h77;
    set_req(3, STOP, 32'h700, 32'h4);
    tick();
    chk("t6_done1", 64'(bus.req_done), 64'h2);
    bus.req_vld[1] = 1'b0;
    wait_done(idx);
    chk("t6_next3", 64'(idx), 64'd3);
    bus.req_vld = '0; bus.tm_ack = 1'b0;
    tick(); tick();

    // Random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!bus.req_vld[i]) begin
          if ($urandom_range(0, 3) == 0)
            set_req(i, ($urandom_range(0, 7) == 0) ? 4'($urandom) : (($urandom_range(0, 1) != 0) ? RUN : STOP),
                    $urandom, $urandom);
        end else if (bus.req_done[i]) begin
          if ($urandom_range(0, 3) != 0) bus.req_vld[i] = 1'b0;
        end else if (bus.busy && int'(bus.gnt_id) == i && $urandom_range(0, 15) == 0) begin
          bus.req_vld[i] = 1'b0;
        end
      end
      bus.tm_ack   = ($urandom_range(0, 2) == 0);
      bus.tm_rslt  = 2'($urandom);
      bus.tm_rdata = $urandom;
      rst          = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0; bus.req_vld = '0; bus.tm_ack = 1'b1;
    for (int k = 0; k < 10; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
